core_axi_rd_arbiter: RTL and testbench

- Shares one AXI4-Lite read port (instruction/data memory) between two read masters.
- M0 is the instruction-fetch unit; M1 is the load unit.
- One transaction is outstanding at a time. The grant is held from address phase through data phase.
- Sits between the core pipeline and the memory interconnect.

---
 rtl/core_axi_rd_arbiter.sv | 137 +++++++++++++
 tb/tb_core_axi_rd_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_axi_rd_arbiter.sv
// core_axi_rd_arbiter: shares one AXI4-Lite read port between the fetch unit (M0) and the load unit (M1).
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (M1 over M0).
module core_axi_rd_arbiter #(
    parameter int AXI_AWIDTH = 4,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  NRST,

    input  logic [AXI_AWIDTH-1:0] M0_ARADDR,
    input  logic                  M0_ARVALID,
    output logic                  M0_ARREADY,
    output logic [AXI_DWIDTH-1:0] M0_RDATA,
    output logic [1:0]            M0_RRESP,
    output logic                  M0_RVALID,
    input  logic                  M0_RREADY,

    input  logic [AXI_AWIDTH-1:0] M1_ARADDR,
    input  logic                  M1_ARVALID,
    output logic                  M1_ARREADY,
    output logic [AXI_DWIDTH-1:0] M1_RDATA,
    output logic [1:0]            M1_RRESP,
    output logic                  M1_RVALID,
    input  logic                  M1_RREADY,

    output logic [AXI_AWIDTH-1:0] S_ARADDR,
    output logic                  S_ARVALID,
    input  logic                  S_ARREADY,
    input  logic [AXI_DWIDTH-1:0] S_RDATA,
    input  logic [1:0]            S_RRESP,
    input  logic                  S_RVALID,
    output logic                  S_RREADY,

    output logic                  GRANT,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q;
    logic   grant_q;
    logic   busy_q;
    logic   arvalid_q;
    logic   rphase_q;
    logic   grant_d;
    logic   any_req;

    assign any_req = M0_ARVALID | M1_ARVALID;

`ifdef ARB_RR_EN
    logic last_q;

    // Contention goes to whoever did not win last time; a lone requester always wins.
    always_comb begin
        grant_d = M1_ARVALID;
        if (M0_ARVALID && M1_ARVALID)
            grant_d = ~last_q;
    end

    always_ff @(posedge CLK) begin
        if (!NRST)
            last_q <= 1'b0;
        else if (state_q == IDLE && any_req)
            last_q <= grant_d;
    end
`else
    always_comb begin
        grant_d = M1_ARVALID;
    end
`endif

    // NOTE: NRST is sampled on the clock edge only (synchronous reset), so it stays out of the sensitivity list.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rphase_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= ADDR;
                        grant_q   <= grant_d;
                        busy_q    <= 1'b1;
                        arvalid_q <= 1'b1;
                    end
                end
                ADDR: begin
                    // arvalid_q is high throughout ADDR, so S_ARREADY alone completes the handshake.
                    if (S_ARREADY) begin
                        state_q   <= DATA;
                        arvalid_q <= 1'b0;
                        rphase_q  <= 1'b1;
                    end
                end
                DATA: begin
                    if (S_RVALID && S_RREADY) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        rphase_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    arvalid_q <= 1'b0;
                    rphase_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GRANT     = grant_q;
    assign BUSY      = busy_q;

    assign S_ARVALID = arvalid_q;
    assign S_ARADDR  = grant_q ? M1_ARADDR : M0_ARADDR;
    assign S_RREADY  = rphase_q & (grant_q ? M1_RREADY : M0_RREADY);

    assign M0_ARREADY = arvalid_q & ~grant_q & S_ARREADY;
    assign M1_ARREADY = arvalid_q &  grant_q & S_ARREADY;

    // Read data and response go to both masters; only RVALID selects the owner.
    assign M0_RVALID = rphase_q & ~grant_q & S_RVALID;
    assign M1_RVALID = rphase_q &  grant_q & S_RVALID;
    assign M0_RDATA  = S_RDATA;
    assign M1_RDATA  = S_RDATA;
    assign M0_RRESP  = S_RRESP;
    assign M1_RRESP  = S_RRESP;

endmodule

// File: tb/tb_core_axi_rd_arbiter.sv
// Scoreboard bench for core_axi_rd_arbiter: directed read transactions from both masters against a simple memory responder.
`timescale 1ns/1ps
module tb_core_axi_rd_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          NRST;
    logic [AW-1:0] M0_ARADDR, M1_ARADDR, S_ARADDR;
    logic          M0_ARVALID, M0_ARREADY, M0_RVALID, M0_RREADY;
    logic          M1_ARVALID, M1_ARREADY, M1_RVALID, M1_RREADY;
    logic [DW-1:0] M0_RDATA, M1_RDATA, S_RDATA;
    logic [1:0]    M0_RRESP, M1_RRESP, S_RRESP;
    logic          S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
    logic          GRANT, BUSY;

    always #5 CLK = ~CLK;

    core_axi_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) dut (
        .CLK(CLK), .NRST(NRST),
        .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
        .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
        .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .GRANT(GRANT), .BUSY(BUSY)
    );

    typedef struct packed { logic m; logic [AW-1:0] addr; } ar_t;
    typedef struct packed { logic m; logic [DW-1:0] data; logic [1:0] resp; } r_t;
    typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; } mem_t;

    ar_t  exp_ar[$];
    r_t   exp_r[$];
    mem_t mem_q[$];

    int checks   = 0;
    int failures = 0;
    bit mem_en;
    int ar_delay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue one expected transaction; call in the order the arbiter should serve them.
    task automatic txn(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] rs);
        exp_ar.push_back('{m: m, addr: a});
        exp_r.push_back('{m: m, data: d, resp: rs});
        mem_q.push_back('{data: d, resp: rs});
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Master-side address phase: hold ARVALID until the arbiter accepts it.
    task automatic m_read(input logic m, input logic [AW-1:0] a);
        bit done;
        done = 1'b0;
        if (m) begin M1_ARADDR = a; M1_ARVALID = 1'b1; end
        else   begin M0_ARADDR = a; M0_ARVALID = 1'b1; end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            done = m ? M1_ARREADY : M0_ARREADY;
        end
        check(m ? "m1_ar_accepted" : "m0_ar_accepted", 32'(done), 32'd1);
        cyc();
        if (m) M1_ARVALID = 1'b0;
        else   M0_ARVALID = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLK);
            ok = (exp_ar.size() == 0) && (exp_r.size() == 0) && !BUSY;
        end
        check("drained_to_idle", 32'(ok), 32'd1);
        cyc();
    endtask

    // Memory responder: ARREADY after ar_delay cycles of S_ARVALID, then one R beat held until accepted.
    initial begin
        int   cnt;
        int   rs;
        bit   sarv, ar_hs, r_hs;
        mem_t m;
        cnt = 0; rs = 0;
        S_ARREADY = 1'b0; S_RVALID = 1'b0; S_RDATA = '0; S_RRESP = 2'b00;
        forever begin
            @(negedge CLK);
            sarv  = S_ARVALID;
            ar_hs = S_ARVALID && S_ARREADY;
            r_hs  = S_RVALID && S_RREADY;
            cyc();
            if (!mem_en) begin
                S_ARREADY = 1'b0; S_RVALID = 1'b0; rs = 0; cnt = 0;
            end else begin
                case (rs)
                    0: if (sarv) begin
                        if (cnt >= ar_delay) begin S_ARREADY = 1'b1; rs = 1; end
                        else cnt++;
                    end
                    1: if (ar_hs) begin
                        if (mem_q.size() != 0) m = mem_q.pop_front();
                        else m = '{data: 32'hDEAD_BEEF, resp: 2'b11};
                        S_ARREADY = 1'b0;
                        S_RDATA   = m.data;
                        S_RRESP   = m.resp;
                        S_RVALID  = 1'b1;
                        rs = 2;
                    end
                    2: if (r_hs) begin S_RVALID = 1'b0; rs = 0; cnt = 0; end
                    default: rs = 0;
                endcase
            end
        end
    end

    // AR monitor: every memory address handshake must match the next expected grant.
    initial forever begin
        @(negedge CLK);
        if (S_ARVALID && S_ARREADY) begin
            ar_t e;
            if (exp_ar.size() == 0) begin
                check("ar_unexpected", 32'(exp_ar.size()), 32'd1);
            end else begin
                e = exp_ar.pop_front();
                check("ar_grant", 32'(GRANT), 32'(e.m));
                check("ar_addr", 32'(S_ARADDR), 32'(e.addr));
                check("ar_ready_granted", 32'(e.m ? M1_ARREADY : M0_ARREADY), 32'd1);
                check("ar_ready_other", 32'(e.m ? M0_ARREADY : M1_ARREADY), 32'd0);
                check("ar_rready_excl", 32'(S_RREADY), 32'd0);
            end
        end
    end

    // R monitor: every master-side data handshake must match the next expected response.
    initial forever begin
        @(negedge CLK);
        if ((M0_RVALID && M0_RREADY) || (M1_RVALID && M1_RREADY)) begin
            r_t e;
            if (exp_r.size() == 0) begin
                check("r_unexpected", 32'(exp_r.size()), 32'd1);
            end else begin
                e = exp_r.pop_front();
                check("r_master", 32'(M1_RVALID), 32'(e.m));
                check("r_other_rvalid", 32'(e.m ? M0_RVALID : M1_RVALID), 32'd0);
                check("r_data", e.m ? M1_RDATA : M0_RDATA, e.data);
                check("r_resp", 32'(e.m ? M1_RRESP : M0_RRESP), 32'(e.resp));
                check("r_grant", 32'(GRANT), 32'(e.m));
                check("r_arvalid_excl", 32'(S_ARVALID), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        logic first;
        NRST = 1'b0;
        M0_ARADDR = '0; M0_ARVALID = 1'b0; M0_RREADY = 1'b1;
        M1_ARADDR = '0; M1_ARVALID = 1'b0; M1_RREADY = 1'b1;
        mem_en = 1'b1; ar_delay = 0;

        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_grant", 32'(GRANT), 32'd0);
        check("rst_s_arvalid", 32'(S_ARVALID), 32'd0);
        check("rst_s_rready", 32'(S_RREADY), 32'd0);
        check("rst_m0_arready", 32'(M0_ARREADY), 32'd0);
        check("rst_m1_arready", 32'(M1_ARREADY), 32'd0);
        check("rst_m0_rvalid", 32'(M0_RVALID), 32'd0);
        check("rst_m1_rvalid", 32'(M1_RVALID), 32'd0);
        cyc();
        NRST = 1'b1;
        cyc();

        // M0 alone, memory slow on ARREADY; S_ARVALID one cycle after the request is sampled
        ar_delay = 2;
        txn(1'b0, 4'h4, 32'h0000_0013, 2'b00);
        fork
            m_read(1'b0, 4'h4);
            begin
                @(negedge CLK);
                check("t1_arvalid_before", 32'(S_ARVALID), 32'd0);
                @(negedge CLK);
                check("t1_arvalid_after", 32'(S_ARVALID), 32'd1);
                check("t1_araddr", 32'(S_ARADDR), 32'h4);
                check("t1_grant", 32'(GRANT), 32'd0);
                check("t1_busy", 32'(BUSY), 32'd1);
            end
        join
        wait_done();
        ar_delay = 1;

        // Both masters in the same cycle, twice back-to-back: M1, M0, M1, M0 with an IDLE gap
        for (int rep = 0; rep < 2; rep++) begin
            txn(1'b1, 4'h8, 32'hCAFE_0001 + rep, 2'b00);
            txn(1'b0, 4'h4, 32'hF00D_0001 + rep, 2'b00);
            fork
                m_read(1'b0, 4'h4);
                m_read(1'b1, 4'h8);
                begin
                    seen = 1'b0;
                    for (int i = 0; i < 100 && !seen; i++) begin
                        @(negedge CLK);
                        seen = M1_RVALID && M1_RREADY;
                    end
                    check("t2_m1_r_seen", 32'(seen), 32'd1);
                    @(negedge CLK);
                    check("t2_gap_busy", 32'(BUSY), 32'd0);
                    check("t2_gap_arvalid", 32'(S_ARVALID), 32'd0);
                    @(negedge CLK);
                    check("t2_m0_arvalid", 32'(S_ARVALID), 32'd1);
                    check("t2_m0_araddr", 32'(S_ARADDR), 32'h4);
                    check("t2_m0_grant", 32'(GRANT), 32'd0);
                end
            join
            wait_done();
        end

        // M1 requests while M0 stalls its data phase; grant must not move
        txn(1'b0, 4'hC, 32'hA5A5_0001, 2'b00);
        txn(1'b1, 4'h8, 32'h5A5A_0002, 2'b00);
        M0_RREADY = 1'b0;
        fork
            m_read(1'b0, 4'hC);
            begin
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge CLK);
                    seen = M0_RVALID;
                end
                check("t3_m0_rvalid_seen", 32'(seen), 32'd1);
                cyc();
                fork
                    m_read(1'b1, 4'h8);
                    begin
                        for (int k = 0; k < 3; k++) begin
                            @(negedge CLK);
                            check("t3_stall_s_rready", 32'(S_RREADY), 32'd0);
                            check("t3_stall_busy", 32'(BUSY), 32'd1);
                            check("t3_stall_arvalid", 32'(S_ARVALID), 32'd0);
                            check("t3_stall_grant", 32'(GRANT), 32'd0);
                            check("t3_stall_m0_rvalid", 32'(M0_RVALID), 32'd1);
                            check("t3_stall_m1_arready", 32'(M1_ARREADY), 32'd0);
                        end
                        cyc();
                        M0_RREADY = 1'b1;
                    end
                join
            end
        join
        wait_done();

        // SLVERR on an M1 read is forwarded and sequencing is unaffected
        txn(1'b1, 4'h6, 32'hBAD0_0BAD, 2'b10);
        m_read(1'b1, 4'h6);
        wait_done();
        check("t4_idle_after_err", 32'(BUSY), 32'd0);

        // Contention right after an M1 grant: round-robin favours M0, fixed priority keeps M1
`ifdef ARB_RR_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        txn(first, first ? 4'h8 : 4'h4, first ? 32'h2000_0001 : 32'h1000_0000, 2'b00);
        txn(~first, first ? 4'h4 : 4'h8, first ? 32'h1000_0000 : 32'h2000_0001, 2'b00);
        fork
            m_read(1'b0, 4'h4);
            m_read(1'b1, 4'h8);
        join
        wait_done();

        // Reset pulse while M1 sits in ADDR abandons the transaction
        mem_en = 1'b0;
        M1_ARADDR = 4'h2;
        M1_ARVALID = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            seen = S_ARVALID;
        end
        check("t5_in_addr", 32'(seen), 32'd1);
        check("t5_grant_m1", 32'(GRANT), 32'd1);
        cyc();
        NRST = 1'b0;
        M1_ARVALID = 1'b0;
        cyc();
        NRST = 1'b1;
        @(negedge CLK);
        check("t5_rst_arvalid", 32'(S_ARVALID), 32'd0);
        check("t5_rst_busy", 32'(BUSY), 32'd0);
        check("t5_rst_grant", 32'(GRANT), 32'd0);
        check("t5_rst_m1_arready", 32'(M1_ARREADY), 32'd0);
        mem_en = 1'b1;
        cyc();
        txn(1'b0, 4'h4, 32'h0000_0077, 2'b00);
        m_read(1'b0, 4'h4);
        wait_done();

        check("sb_empty", 32'(exp_ar.size() + exp_r.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
